dct_2d_stream: RTL and testbench

//  Parametrised 8x8 2D DCT-II (orthonormal) for the JPEG encoder datapath, sitting between level-shift and quantiser.

---
 rtl/dct_pkg.sv | 27 ++
 rtl/dct_1d_lane.sv | 38 +++
 rtl/dct_2d_stream.sv | 145 ++++++++++++++
 tb/tb_dct_2d_stream.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: cosine coefficients, zigzag LUT, rounding helper and FSM states for dct_2d_stream
package dct_pkg;
  localparam int COEF_W = 14;
  localparam int COEF_FRAC = 12;
  localparam int DC_COEF = 1448;
  localparam int COS_TAB [9] = '{2048, 2009, 1892, 1703, 1448, 1138, 784, 400, 0};
  localparam int ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  typedef enum logic [1:0] {IDLE, ROW_RUN, COL_RUN, OUT_HOLD} state_t;
  // C(k)/2*cos((2n+1)k*pi/16) scaled by 2^12, folded onto the first quadrant table
  function automatic logic signed [COEF_W-1:0] coef(input int k, input int n);
    int m;
    int v;
    m = ((2 * n + 1) * k) % 32;
    m = m > 16 ? 32 - m : m;
    v = m > 8 ? -COS_TAB[16 - m] : COS_TAB[m];
    return k == 0 ? COEF_W'(DC_COEF) : COEF_W'(v);
  endfunction
  // drop sh fraction bits, ties rounded away from zero
  function automatic logic signed [63:0] round_sh(input logic signed [63:0] s, input int sh);
    return (s + (64'sd1 <<< (sh - 1)) - (s < 0 ? 64'sd1 : 64'sd0)) >>> sh;
  endfunction
endpackage

// File: rtl/dct_1d_lane.sv
// dct_1d_lane: 8-point orthonormal DCT-II with full-precision sums and an LAT-stage output pipeline
module dct_1d_lane
  import dct_pkg::*;
#(
  parameter int IW  = 16,
  parameter int OW  = IW + COEF_W + 3,
  parameter int LAT = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [8*IW-1:0] x,
  output logic [8*OW-1:0] y
);
  logic signed [OW-1:0] acc [8];
  logic [8*OW-1:0] flat;
  logic [8*OW-1:0] pipe [LAT];

  always_comb begin
    flat = '0;
    for (int k = 0; k < 8; k++) begin
      acc[k] = '0;
      for (int n = 0; n < 8; n++)
        acc[k] = acc[k] + OW'($signed(x[n*IW +: IW])) * OW'(coef(k, n));
      flat[k*OW +: OW] = acc[k];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= flat;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[LAT-1];
endmodule

// File: rtl/dct_2d_stream.sv
// dct_2d_stream: streaming 8x8 orthonormal 2D DCT-II, row pass then column pass over LANES shared 1D lanes
// DCT_ZIGZAG_EN: emit coefficients in JPEG zigzag order instead of row-major u*8+v
module dct_2d_stream
  import dct_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int OUT_W   = 12,
  parameter int LANES   = 2,
  parameter int DCT_LAT = 3,
  parameter int MID_W   = IN_W + 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [64*IN_W-1:0] in_block,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [64*OUT_W-1:0] out_block,
  output logic               out_sat,
  output logic               busy
);
  localparam int N = 8 / LANES;
  localparam int ACC_W = MID_W + COEF_W + 3;
  localparam int CW = $clog2(N + DCT_LAT + 2);
  localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_LO = -SAT_HI - 64'sd1;
`ifdef DCT_ZIGZAG_EN
  localparam bit ZZ = 1'b1;
`else
  localparam bit ZZ = 1'b0;
`endif

  state_t state;
  logic [CW-1:0] cnt;
  logic rdy, col, cap;
  logic [64*IN_W-1:0] pix;
  logic signed [MID_W-1:0] mid [64];
  logic signed [OUT_W-1:0] res [64];
  logic [63:0] clip;
  logic [2:0] isel [LANES];
  logic [2:0] csel [LANES];
  logic [8*MID_W-1:0] lane_x [LANES];
  logic [8*ACC_W-1:0] lane_y [LANES];
  logic signed [MID_W-1:0] rmid [LANES][8];
  logic signed [OUT_W-1:0] rout [LANES][8];
  logic rclip [LANES][8];

  assign in_ready = rdy & reset_n;
  assign busy = state != IDLE;
  assign col = state == COL_RUN;
  assign cap = (state == ROW_RUN || col) && int'(cnt) >= DCT_LAT && int'(cnt) < N + DCT_LAT;

  // isel picks the row/column issued this cycle, csel the one whose lane result lands now
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      isel[l] = 3'(int'(cnt) * LANES + l);
      csel[l] = 3'((int'(cnt) - DCT_LAT) * LANES + l);
      lane_x[l] = '0;
      for (int n = 0; n < 8; n++)
        lane_x[l][n*MID_W +: MID_W] = col ? mid[n*8 + int'(isel[l])]
                                          : MID_W'($signed(pix[(int'(isel[l])*8 + n)*IN_W +: IN_W]));
    end
  end

  // row pass keeps one fraction bit, column pass rounds to integer and clips
  always_comb begin : p_round
    logic signed [63:0] t;
    t = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 8; k++) begin
        t = round_sh(64'($signed(lane_y[l][k*ACC_W +: ACC_W])), col ? COEF_FRAC + 1 : COEF_FRAC - 1);
        rmid[l][k] = MID_W'(t);
        rclip[l][k] = t > SAT_HI || t < SAT_LO;
        rout[l][k] = t > SAT_HI ? OUT_W'(SAT_HI) : t < SAT_LO ? OUT_W'(SAT_LO) : OUT_W'(t);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dct_1d_lane #(.IW(MID_W), .OW(ACC_W), .LAT(DCT_LAT)) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .x      (lane_x[g]),
      .y      (lane_y[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      rdy <= 1'b1;
      out_valid <= 1'b0;
      out_block <= '0;
      out_sat <= 1'b0;
      pix <= '0;
      clip <= '0;
      for (int i = 0; i < 64; i++) begin
        mid[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          pix <= in_block;
          cnt <= '0;
          rdy <= 1'b0;
          state <= ROW_RUN;
        end
        ROW_RUN: begin
          cnt <= int'(cnt) == N + DCT_LAT - 1 ? '0 : cnt + 1'b1;
          state <= int'(cnt) == N + DCT_LAT - 1 ? COL_RUN : ROW_RUN;
        end
        COL_RUN: begin
          cnt <= cnt + 1'b1;
          if (int'(cnt) == N + DCT_LAT) begin
            for (int k = 0; k < 64; k++) out_block[k*OUT_W +: OUT_W] <= res[ZZ ? ZIGZAG[k] : k];
            out_sat <= |clip;
            out_valid <= 1'b1;
            state <= OUT_HOLD;
          end
        end
        OUT_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (cap) begin
        for (int l = 0; l < LANES; l++) begin
          for (int k = 0; k < 8; k++) begin
            if (col) begin
              res[k*8 + int'(csel[l])] <= rout[l][k];
              clip[k*8 + int'(csel[l])] <= rclip[l][k];
            end else begin
              mid[int'(csel[l])*8 + k] <= rmid[l][k];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dct_2d_stream.sv
// tb_dct_2d_stream: three DUTs (LANES=1,2,8) fed the same blocks, checked against a real-cosine reference model
module tb_dct_2d_stream;
  localparam int W = 12;
  localparam int LN [3] = '{1, 2, 8};
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic [64*W-1:0] in_block = '0;
  logic ordy [3] = '{1'b1, 1'b1, 1'b1};
  logic rdy [3];
  logic ov [3];
  logic sat [3];
  logic bsy [3];
  logic [64*W-1:0] ob [3];
  logic [64*W-1:0] last [3];
  logic lsat [3];
  int total = 0;
  int bad = 0;
  int cf [8][8];
  int opos [64];
  int ex [64];
  bit es;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dct_2d_stream #(.LANES(LN[g])) u_dut (
      .clock    (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (rdy[g]),
      .in_block (in_block),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_block(ob[g]),
      .out_sat  (sat[g]),
      .busy     (bsy[g])
    );
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rha(input longint s, input int sh);
    longint a, q;
    a = s < 0 ? -s : s;
    q = (a + (longint'(1) << (sh - 1))) >> sh;
    return s < 0 ? -q : q;
  endfunction

  function automatic int at(input logic [64*W-1:0] b, input int nat);
    return int'($signed(b[opos[nat]*W +: W]));
  endfunction

  task automatic model(input int px [64]);
    int m [64];
    longint s, t;
    es = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int v = 0; v < 8; v++) begin
        s = 0;
        for (int n = 0; n < 8; n++) s += longint'(px[r*8+n]) * cf[v][n];
        m[r*8+v] = int'(rha(s, 11));
      end
    for (int u = 0; u < 8; u++)
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int n = 0; n < 8; n++) s += longint'(m[n*8+c]) * cf[u][n];
        t = rha(s, 13);
        if (t > 2047) begin t = 2047; es = 1'b1; end
        if (t < -2048) begin t = -2048; es = 1'b1; end
        ex[u*8+c] = int'(t);
      end
  endtask

  task automatic run(input int px [64], input bit hold);
    int seen [3];
    bit done [3];
    int lat, d;
    model(px);
    for (int k = 0; k < 64; k++) in_block[k*W +: W] = W'(px[k]);
    for (int c = 0; c < 100 && !(rdy[0] && rdy[1] && rdy[2]); c++) @(negedge clk);
    chk("idle_before_accept", rdy[0] && rdy[1] && rdy[2], 1);
    for (int i = 0; i < 3; i++) begin
      ordy[i] = !hold;
      seen[i] = -1;
      done[i] = 1'b0;
    end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 200 && !(done[0] && done[1] && done[2]); c++) begin
      for (int i = 0; i < 3; i++) begin
        lat = 2 * (8 / LN[i] + 3) + 1;
        if (c == 0) begin
          chk($sformatf("busy_after_accept[%0d]", i), bsy[i], 1);
          chk($sformatf("in_ready_busy[%0d]", i), rdy[i], 0);
        end
        if (seen[i] < 0) begin
          if (ov[i]) begin
            seen[i] = c;
            chk($sformatf("latency[%0d]", i), c, lat);
            for (int k = 0; k < 64; k++) chk($sformatf("coef[%0d][%0d]", i, k), at(ob[i], k), ex[k]);
            chk($sformatf("out_sat[%0d]", i), sat[i], es);
            last[i] = ob[i];
            lsat[i] = sat[i];
          end
        end else if (!done[i]) begin
          d = c - seen[i];
          if (hold && d <= 20) begin
            chk($sformatf("hold_valid[%0d]", i), ov[i], 1);
            chk($sformatf("hold_block[%0d]", i), ob[i] == last[i], 1);
            chk($sformatf("hold_sat[%0d]", i), sat[i], es);
            chk($sformatf("hold_in_ready[%0d]", i), rdy[i], 0);
            if (d == 20) ordy[i] = 1'b1;
          end else begin
            chk($sformatf("valid_drop[%0d]", i), ov[i], 0);
            chk($sformatf("ready_back[%0d]", i), rdy[i], 1);
            done[i] = 1'b1;
          end
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (!done[i]) chk($sformatf("timeout[%0d]", i), 0, 1);
      ordy[i] = 1'b1;
    end
  endtask

  initial begin
    int px [64];
    int k;
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++)
        cf[u][n] = int'((u == 0 ? 1.0 / $sqrt(2.0) : 1.0) * 0.5 * $cos((2 * n + 1) * u * PI / 16.0) * 4096.0);
    for (int i = 0; i < 64; i++) opos[i] = i;
`ifdef DCT_ZIGZAG_EN
    k = 0;
    for (int s = 0; s < 15; s++)
      for (int j = 0; j < 8; j++) begin
        int u;
        u = (s % 2 == 0) ? ((s < 7 ? s : 7) - j) : ((s > 7 ? s - 7 : 0) + j);
        if (u >= 0 && u <= 7 && s - u >= 0 && s - u <= 7) begin
          opos[u*8 + s - u] = k;
          k++;
        end
      end
`else
    k = 0;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), rdy[i], 0);
      chk($sformatf("rst_valid[%0d]", i), ov[i], 0);
      chk($sformatf("rst_block[%0d]", i), ob[i] == '0, 1);
      chk($sformatf("rst_sat[%0d]", i), sat[i], 0);
      chk($sformatf("rst_busy[%0d]", i), bsy[i], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("post_rst_ready[%0d]", i), rdy[i], 1);

    for (int i = 0; i < 64; i++) px[i] = 0;
    run(px, 0);
    for (int i = 0; i < 64; i++) px[i] = 100;
    run(px, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("dc100[%0d]", i), at(last[i], 0), 800);
    for (int i = 0; i < 64; i++) px[i] = 2047;
    run(px, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dc2047[%0d]", i), at(last[i], 0), 2047);
      chk($sformatf("sat2047[%0d]", i), lsat[i], 1);
    end
    for (int i = 0; i < 64; i++) px[i] = i < 32 ? 100 : -100;
    run(px, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("f10_near_725[%0d]", i), (at(last[i], 8) - 725) inside {[-1:1]}, 1);
    for (int i = 0; i < 64; i++) px[i] = int'($urandom_range(511)) - 256;
    run(px, 1);

    for (int i = 0; i < 64; i++) px[i] = 100;
    for (int i = 0; i < 64; i++) in_block[i*W +: W] = W'(px[i]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_valid[%0d]", i), ov[i], 0);
      chk($sformatf("midrst_busy[%0d]", i), bsy[i], 0);
      chk($sformatf("midrst_in_ready[%0d]", i), rdy[i], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_ready_back[%0d]", i), rdy[i], 1);
      chk($sformatf("midrst_idle[%0d]", i), bsy[i], 0);
    end
    run(px, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("dc100_after_rst[%0d]", i), at(last[i], 0), 800);

    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 64; i++)
        px[i] = b % 2 == 0 ? int'($urandom_range(4095)) - 2048 : int'($urandom_range(255)) - 128;
      run(px, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
